latch_strobe_tx: RTL and testbench
==================================

LATCH_STROBE_TX -- requirements
Module: latch_strobe_tx

Interface
REQ-001 Parameter DATA_W, default 8, frame width in bits (>=1).
REQ-002 Parameter SETUP_CYC, default 2, cycles d is stable before enable rises (>=1).
REQ-003 Parameter EN_CYC, default 1, cycles enable is held high per bit (>=1).
REQ-004 Parameter HOLD_CYC, default 1, cycles d is held after enable falls (>=1).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_data  input  DATA_W  parallel word to transmit.
REQ-008 in_valid  input  1  in_data is offered.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 d  output  1  serial data bit toward a downstream enable latch.
REQ-011 enable  output  1  latch strobe; downstream latch is transparent while high.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  one-cycle pulse on frame completion.

Function
REQ-014 The block SHALL implement the FSM IDLE, SETUP, STROBE, HOLD; all outputs SHALL be registered.
REQ-015 in_ready SHALL be 1 exactly when state is IDLE; busy SHALL equal the inverse of in_ready.
REQ-016 A word SHALL be accepted on an edge where in_valid=1 and in_ready=1: shift register loads in_data, d takes in_data[DATA_W-1], bit counter clears, state becomes SETUP.
REQ-017 Bits SHALL be sent MSB first; d SHALL change only on the edge entering SETUP.
REQ-018 SETUP SHALL last SETUP_CYC cycles with enable=0, then STROBE.
REQ-019 STROBE SHALL last EN_CYC cycles with enable=1, then HOLD.
REQ-020 HOLD SHALL last HOLD_CYC cycles with enable=0, d unchanged; then SETUP with the next bit, or IDLE after bit DATA_W-1.
REQ-021 Bit period SHALL be SETUP_CYC+EN_CYC+HOLD_CYC cycles; frame latency from acceptance edge to IDLE SHALL be DATA_W times that.
REQ-022 done SHALL be 1 for exactly the first IDLE cycle after a frame; in_ready SHALL be 1 in that same cycle, permitting back-to-back frames with no gap cycle.
REQ-023 in_valid and in_data SHALL be ignored while busy=1; the frame in progress SHALL NOT be altered.
REQ-024 In IDLE d SHALL hold the last transmitted bit (0 after reset) and enable SHALL be 0.
REQ-025 enable SHALL never be high in the same cycle d changes.
REQ-026 Internal counters SHALL be sized ceil(log2(max+1)) of their range and SHALL NOT wrap within a phase.

Reset
REQ-027 On an edge with rst_n=0 the block SHALL enter IDLE with d=0, enable=0, done=0, busy=0, in_ready=1, counters and shift register cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a done pulse; enable SHALL be 0 from the next cycle.
REQ-029 in_valid SHALL be ignored on any edge where rst_n=0.

Verification (DATA_W=8, SETUP_CYC=2, EN_CYC=1, HOLD_CYC=1)
REQ-030 Reset held 3 cycles, then released -> d=0, enable=0, busy=0, in_ready=1, done=0.
REQ-031 Send 0xA5 -> d sequence 1,0,1,0,0,1,0,1; enable high 1 cycle at cycle offsets 2,6,...,30 after acceptance; done at cycle 32; busy high for cycles 0-31.
REQ-032 in_valid held high with 0x3C then 0xC3 -> second word accepted in the done cycle of the first; 64 cycles total, no idle gap.
REQ-033 in_valid=1 with 0xFF during a 0x00 frame -> d stays 0 for all 8 bits; 0xFF not transmitted.
REQ-034 rst_n=0 at cycle 13 of a frame -> next cycle enable=0, d=0, in_ready=1; no done pulse.
REQ-035 Checker on every run: d never changes while enable=1; enable pulse count per frame equals DATA_W.

Source files
------------

// File: rtl/latch_strobe_tx.sv
// +----------------------------------------------------------------------------+
// | latch_strobe_tx : serialises a word MSB first as d + enable strobe pairs    |
// | for a downstream enable latch (setup / strobe / hold per bit).              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module latch_strobe_tx #(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              d,
  output logic              enable,
  output logic              busy,
  output logic              done
);

  localparam int C_MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int C_MAX_CYC = (C_MAX_A > HOLD_CYC) ? C_MAX_A : HOLD_CYC;
  localparam int PH_W      = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;
  localparam int BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [PH_W-1:0]  c_setup_last = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]  c_en_last    = PH_W'(EN_CYC - 1);
  localparam logic [PH_W-1:0]  c_hold_last  = PH_W'(HOLD_CYC - 1);
  localparam logic [BIT_W-1:0] c_last_bit   = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  logic [PH_W-1:0]     r_phase;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DATA_W-1:0]   r_shreg;

  state_t              w_state_nxt;
  logic [PH_W-1:0]     w_phase_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [DATA_W-1:0]   w_shreg_nxt;
  logic [DATA_W-1:0]   w_shift;
  logic                w_d_nxt;
  logic                w_done_nxt;

  assign w_shift = r_shreg << 1;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_d_nxt     = d;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_SETUP;
          w_shreg_nxt = in_data;
          w_d_nxt     = in_data[DATA_W-1];
          w_bit_nxt   = '0;
          w_phase_nxt = '0;
        end
      end
      S_SETUP: begin
        if (r_phase == c_setup_last) begin
          w_state_nxt = S_STROBE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      S_STROBE: begin
        if (r_phase == c_en_last) begin
          w_state_nxt = S_HOLD;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      S_HOLD: begin
        if (r_phase == c_hold_last) begin
          w_phase_nxt = '0;
          if (r_bit_cnt == c_last_bit) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            // d only moves on the edge into SETUP, so it is stable around the strobe
            w_state_nxt = S_SETUP;
            w_bit_nxt   = r_bit_cnt + BIT_W'(1);
            w_shreg_nxt = w_shift;
            w_d_nxt     = w_shift[DATA_W-1];
          end
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      d         <= 1'b0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
      d         <= w_d_nxt;
      enable    <= (w_state_nxt == S_STROBE);
      busy      <= (w_state_nxt != S_IDLE);
      in_ready  <= (w_state_nxt == S_IDLE);
      done      <= w_done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_latch_strobe_tx.sv
// Directed bench for latch_strobe_tx (DATA_W=8, SETUP=2, EN=1, HOLD=1): outputs
// sampled on the falling edge and compared with hand-derived frame timing.
`default_nettype none

module tb_latch_strobe_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       d;
  logic       enable;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int pulses;
  logic prev_d;
  logic prev_en;

  latch_strobe_tx #(
    .DATA_W   (8),
    .SETUP_CYC(2),
    .EN_CYC   (1),
    .HOLD_CYC (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .d       (d),
    .enable  (enable),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_d);
    chk({tag, ".d"}, {31'd0, d}, {31'd0, exp_d});
    chk({tag, ".enable"}, {31'd0, enable}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
  endtask

  // Entered at the falling edge of cycle 0 after acceptance; leaves at cycle 33.
  task automatic check_frame(input string tag, input logic [7:0] w,
                             input logic v_mid, input logic [7:0] x_mid,
                             input logic v_end, input logic [7:0] x_end);
    for (int k = 0; k <= 32; k++) begin
      logic exp_d;
      exp_d = (k < 32) ? w[7 - k/4] : w[0];
      chk($sformatf("%s.d[%0d]", tag, k), {31'd0, d}, {31'd0, exp_d});
      chk($sformatf("%s.enable[%0d]", tag, k), {31'd0, enable},
          {31'd0, (k < 32) && (k % 4 == 2)});
      chk($sformatf("%s.busy[%0d]", tag, k), {31'd0, busy}, {31'd0, k < 32});
      chk($sformatf("%s.in_ready[%0d]", tag, k), {31'd0, in_ready}, {31'd0, k == 32});
      chk($sformatf("%s.done[%0d]", tag, k), {31'd0, done}, {31'd0, k == 32});
      if (k < 32) begin
        in_valid = v_mid;
        in_data  = x_mid;
      end else begin
        in_valid = v_end;
        in_data  = x_end;
      end
      @(negedge clk);
    end
  endtask

  // Protocol monitor: d stable under enable, DATA_W strobes per completed frame.
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      chk("mon.d_stable_under_enable", {31'd0, d}, {31'd0, prev_d});
      if (prev_en !== 1'b1) pulses++;
    end
    if (done === 1'b1) begin
      chk("mon.pulses_per_frame", pulses, 32'd8);
      pulses = 0;
    end else if (in_ready === 1'b1) begin
      pulses = 0;
    end
    prev_d  = d;
    prev_en = enable;
  end

  initial begin
    checks   = 0;
    errors   = 0;
    pulses   = 0;
    prev_d   = 1'b0;
    prev_en  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset held 3 cycles then released
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 1'b0);

    // Single frame 0xA5
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    check_frame("a5", 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
    check_idle("a5_after", 1'b1);

    // Back-to-back 0x3C then 0xC3 with in_valid held high
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    check_frame("b2b_3c", 8'h3C, 1'b1, 8'hC3, 1'b1, 8'hC3);
    check_frame("b2b_c3", 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00);
    check_idle("b2b_after", 1'b1);

    // 0x00 frame with 0xFF offered throughout; must not disturb it
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    check_frame("zero", 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00);
    check_idle("zero_after", 1'b0);

    // Reset asserted at cycle 13 of a 0xFF frame, in_valid high during reset
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort.pre_d", {31'd0, d}, 32'd1);
    chk("abort.pre_busy", {31'd0, busy}, 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check_idle("abort", 1'b0);
    @(negedge clk);
    check_idle("abort_hold", 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("abort_release[%0d]", i), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
